poly_voice_allocator: RTL

- Successor to the fixed 8-voice keyboard front end of the Verisynth core.
- Turns MiSTer ps2_key events into per-voice note/gate/trigger state for a parametrised number of synth voices.
- Adds over the fixed-voice keyboard: LRU voice stealing, same-key retrigger, sustain pedal and octave transpose.
- Sits between hps_io ps2_key and the synthesizer's per-voice frequency/envelope logic, in the clk_sys domain.

---
 rtl/poly_synth_pkg.sv | 16 +
 rtl/poly_voice_allocator_if.sv | 12 +
 rtl/poly_voice_allocator_scancode_to_key.sv | 42 ++++
 rtl/poly_voice_allocator.sv | 114 +++++++++++
 4 files changed

// File: rtl/poly_synth_pkg.sv
// poly_synth_pkg: shared widths, voice record and ps2_key bit positions for the voice allocator
package poly_synth_pkg;
  localparam int KEY_W = 5;
  localparam int NOTE_W = 7;
  localparam int SC_EXT = 8;
  localparam int SC_PRESS = 9;
  localparam int SC_STROBE = 10;
  typedef logic [KEY_W-1:0] key_t;
  typedef logic [NOTE_W-1:0] note_t;
  typedef struct packed {
    key_t key;
    note_t note;
    logic gate;
    logic pending;
  } voice_t;
endpackage

// File: rtl/poly_voice_allocator_if.sv
// poly_voice_allocator_if: keyboard/pedal inputs and per-voice outputs of the allocator
interface poly_voice_allocator_if #(parameter int NUM_VOICES = 8);
  logic [10:0] ps2_key;
  logic [2:0] octave;
  logic sustain;
  logic [NUM_VOICES*7-1:0] voice_note;
  logic [NUM_VOICES-1:0] voice_gate;
  logic [NUM_VOICES-1:0] voice_trig;
  logic [4:0] active_count;
  modport master (output ps2_key, octave, sustain, input voice_note, voice_gate, voice_trig, active_count);
  modport slave (input ps2_key, octave, sustain, output voice_note, voice_gate, voice_trig, active_count);
endinterface

// File: rtl/poly_voice_allocator_scancode_to_key.sv
// scancode_to_key: ps2 set-2 scancode to two-octave piano key index
module scancode_to_key
  import poly_synth_pkg::*;
(
  input  logic [7:0] i_sc,
  output logic       o_valid,
  output key_t       o_key
);
  always_comb begin
    o_valid = 1'b1;
    o_key = '0;
    case (i_sc)
      8'h1A: o_key = 5'd0;
      8'h1B: o_key = 5'd1;
      8'h22: o_key = 5'd2;
      8'h23: o_key = 5'd3;
      8'h21: o_key = 5'd4;
      8'h2A: o_key = 5'd5;
      8'h34: o_key = 5'd6;
      8'h32: o_key = 5'd7;
      8'h33: o_key = 5'd8;
      8'h31: o_key = 5'd9;
      8'h3B: o_key = 5'd10;
      8'h3A: o_key = 5'd11;
      8'h41: o_key = 5'd12;
      8'h15: o_key = 5'd12;
      8'h1E: o_key = 5'd13;
      8'h1D: o_key = 5'd14;
      8'h26: o_key = 5'd15;
      8'h24: o_key = 5'd16;
      8'h2D: o_key = 5'd17;
      8'h2E: o_key = 5'd18;
      8'h2C: o_key = 5'd19;
      8'h36: o_key = 5'd20;
      8'h35: o_key = 5'd21;
      8'h3D: o_key = 5'd22;
      8'h3C: o_key = 5'd23;
      8'h43: o_key = 5'd24;
      default: o_valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/poly_voice_allocator.sv
// poly_voice_allocator: ps2 key events to polyphonic voice note/gate/trigger with LRU stealing and sustain
module poly_voice_allocator
  import poly_synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int BASE_NOTE = 48,
  parameter int STEAL_EN = 1
) (
  input logic clk,
  input logic reset,
  poly_voice_allocator_if.slave bus
);
  localparam int RW = 4;
  logic r_prev_strobe, r_sus, r_s1_valid, r_s1_press;
  key_t r_s1_key;
  note_t r_s1_note;
  voice_t r_v [NUM_VOICES];
  logic [RW-1:0] r_rank [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_trig;
  logic [4:0] r_cnt;
  logic w_event, w_map_valid;
  key_t w_map_key;
  logic signed [8:0] w_oct, w_sum;
  note_t w_note;
  voice_t w_v [NUM_VOICES];
  logic [RW-1:0] w_rank [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_trig;
  logic [4:0] w_cnt;
  logic w_hit, w_free, w_alloc;
  logic [RW-1:0] w_hit_idx, w_free_idx, w_old_idx, w_sel, w_sel_rank;
  scancode_to_key u_map (.i_sc(bus.ps2_key[7:0]), .o_valid(w_map_valid), .o_key(w_map_key));
  assign w_event = bus.ps2_key[SC_STROBE] != r_prev_strobe;
  assign w_oct = {{6{bus.octave[2]}}, bus.octave};
  assign w_sum = 9'(BASE_NOTE) + signed'({4'b0, w_map_key}) + w_oct * 9'sd12;
  assign w_note = w_sum < 0 ? 7'd0 : w_sum > 9'sd127 ? 7'd127 : w_sum[6:0];
  always_comb begin
    w_hit = 1'b0;
    w_free = 1'b0;
    w_hit_idx = '0;
    w_free_idx = '0;
    w_old_idx = '0;
    w_sel_rank = '0;
    w_trig = '0;
    w_cnt = '0;
    w_rank = r_rank;
    // sustain release lands before this cycle's event so freed voices are reusable
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_v[v] = r_v[v];
      if (r_sus && !bus.sustain && r_v[v].pending) begin
        w_v[v].gate = 1'b0;
        w_v[v].pending = 1'b0;
      end
    end
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (w_v[v].gate && w_v[v].key == r_s1_key) begin
        w_hit = 1'b1;
        w_hit_idx = RW'(v);
      end
      if (!w_v[v].gate) begin
        w_free = 1'b1;
        w_free_idx = RW'(v);
      end
      if (r_rank[v] == RW'(NUM_VOICES - 1)) w_old_idx = RW'(v);
    end
    w_alloc = r_s1_valid && r_s1_press && (w_hit || w_free || STEAL_EN != 0);
    w_sel = w_hit ? w_hit_idx : w_free ? w_free_idx : w_old_idx;
    for (int v = 0; v < NUM_VOICES; v++)
      if (RW'(v) == w_sel) w_sel_rank = r_rank[v];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (w_alloc) begin
        w_rank[v] = RW'(v) == w_sel ? '0 : r_rank[v] < w_sel_rank ? r_rank[v] + 1'b1 : r_rank[v];
        if (RW'(v) == w_sel) begin
          w_v[v] = '{key: r_s1_key, note: r_s1_note, gate: 1'b1, pending: 1'b0};
          w_trig[v] = 1'b1;
        end
      end else if (r_s1_valid && !r_s1_press && w_hit && RW'(v) == w_hit_idx) begin
        w_v[v].pending = bus.sustain;
        w_v[v].gate = bus.sustain;
      end
      w_cnt = w_cnt + 5'(w_v[v].gate);
    end
  end
  always_ff @(posedge clk) begin
    r_prev_strobe <= bus.ps2_key[SC_STROBE];
    r_sus <= bus.sustain;
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_press <= 1'b0;
      r_s1_key <= '0;
      r_s1_note <= '0;
      r_trig <= '0;
      r_cnt <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_v[v] <= '0;
        r_rank[v] <= RW'(v);
      end
    end else begin
      r_s1_valid <= w_event && !bus.ps2_key[SC_EXT] && w_map_valid;
      r_s1_press <= bus.ps2_key[SC_PRESS];
      r_s1_key <= w_map_key;
      r_s1_note <= w_note;
      r_trig <= w_trig;
      r_cnt <= w_cnt;
      r_v <= w_v;
      r_rank <= w_rank;
    end
  end
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_out
    assign bus.voice_note[7*i+:7] = r_v[i].note;
    assign bus.voice_gate[i] = r_v[i].gate;
  end
  assign bus.voice_trig = r_trig;
  assign bus.active_count = r_cnt;
endmodule
